// File: rtl/fb_scanout_arbiter_if.sv
// Framebuffer bus between the scanout arbiter, the PPU write port and the single-port RAM.
// The master modport is the arbiter side; the slave modport is the PPU/RAM side.
interface fb_scanout_arbiter_if;
    logic        ppu_req;
    logic [15:0] ppu_addr;
    logic [5:0]  ppu_data;
    logic        ppu_gnt;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [5:0]  mem_wdata;
    logic [5:0]  mem_rdata;

    modport master (
        input  ppu_req, ppu_addr, ppu_data, mem_rdata,
        output ppu_gnt, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output ppu_req, ppu_addr, ppu_data, mem_rdata,
        input  ppu_gnt, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_scanout_arbiter.sv
// Shares the framebuffer RAM between PPU writes and row prefetch into a ping-pong line
// buffer, and scans out a 2x-scaled 512x480 image centred in the 640x480 VGA area.
module fb_scanout_arbiter #(
    parameter int X_OFFSET = 64,
    parameter int ROWS     = 240
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    fb_scanout_arbiter_if.master        bus,
    output logic [5:0]                  pix_index,
    output logic                        pix_valid,
    output logic                        underrun
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [16:0] ROW_LIMIT = 17'(ROWS * 256);
    localparam logic [10:0] WIN_LO    = 11'(X_OFFSET);
    localparam logic [10:0] WIN_HI    = 11'(X_OFFSET + 512);

    logic [1:0] state;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] col_tag;
    logic       rd_pending;
    logic       last_ppu;
    logic       primed;

    logic [5:0] line_buf [0:511];

    logic       trigger;
    logic [7:0] trig_row;

    // Odd lines prefetch the row shown from the next line on; line 524 prefetches row 0.
    always_comb begin
        trigger  = 1'b0;
        trig_row = '0;
        if (DrawX == 10'd0) begin
            if (DrawY[0] && (DrawY < 10'd479)) begin
                trigger  = 1'b1;
                trig_row = DrawY[8:1] + 8'd1;
            end else if (DrawY == 10'd524) begin
                trigger  = 1'b1;
            end
        end
    end

    logic fetch_req;
    logic ppu_gnt_int;
    logic fetch_gnt;

    // NOTE: grants are gated by Reset so the combinational RAM controls drop to zero
    // the moment reset asserts, not at the next clock edge.
    assign fetch_req   = Reset && (state == FETCH) && !trigger;
    assign ppu_gnt_int = Reset && bus.ppu_req && (!fetch_req || !last_ppu);
    assign fetch_gnt   = fetch_req && !ppu_gnt_int;

    assign bus.ppu_gnt   = ppu_gnt_int;
    assign bus.mem_we    = ppu_gnt_int && ({1'b0, bus.ppu_addr} < ROW_LIMIT);
    assign bus.mem_wdata = ppu_gnt_int ? bus.ppu_data : 6'd0;

    always_comb begin
        bus.mem_addr = '0;
        if (ppu_gnt_int) begin
            bus.mem_addr = bus.ppu_addr;
        end else if (fetch_gnt) begin
            bus.mem_addr = {row, col};
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            col_tag    <= '0;
            rd_pending <= 1'b0;
            last_ppu   <= 1'b1;
            primed     <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            rd_pending <= fetch_gnt;
            if (ppu_gnt_int || fetch_gnt) begin
                last_ppu <= ppu_gnt_int;
            end
            if (fetch_gnt) begin
                col_tag <= col;
            end
            // A new trigger always wins: a late fetch is abandoned and flagged.
            if (trigger) begin
                if (state != IDLE) begin
                    underrun <= 1'b1;
                end
                state <= FETCH;
                row   <= trig_row;
                col   <= '0;
            end else begin
                case (state)
                    FETCH: begin
                        if (fetch_gnt) begin
                            col <= col + 8'd1;
                            if (col == 8'd255) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (rd_pending) begin
                            state  <= IDLE;
                            primed <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // NOTE: the line buffer is plain storage with no reset; primed keeps stale contents
    // from ever reaching pix_valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge Clk) begin
        if (rd_pending && !trigger) begin
            line_buf[{row[0], col_tag}] <= bus.mem_rdata;
        end
    end

    logic [10:0] nx;
    logic [10:0] rel;
    logic [7:0]  rd_col;
    logic        in_window;

    assign nx        = {1'b0, DrawX} + 11'd1;
    assign rel       = nx - WIN_LO;
    assign rd_col    = 8'(rel >> 1);
    assign in_window = primed && (DrawY < 10'd480) && (nx >= WIN_LO) && (nx < WIN_HI);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pix_index <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_index <= in_window ? line_buf[{DrawY[1], rd_col}] : 6'd0;
            pix_valid <= in_window;
        end
    end
endmodule
